// File: rtl/eth_rx_packet_checker.sv
// Checks received AXI-Stream test frames (beat index in LSBs, fixed pattern above it)
// and reports per-frame verdicts plus saturating good/bad/beat-error statistics.
module eth_rx_packet_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]           s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s00_axis_tkeep,
    input  logic                            s00_axis_tvalid,
    input  logic                            s00_axis_tlast,
    input  logic                            s00_axis_tuser,
    input  logic                            cfg_enable,
    input  logic [SEQ_WIDTH-1:0]            cfg_length,
    input  logic [DATA_WIDTH-SEQ_WIDTH-1:0] cfg_hi_pattern,
    input  logic                            cfg_check_hi,
    input  logic                            stat_clear,
    output logic                            frame_done,
    output logic                            frame_ok,
    output logic [3:0]                      frame_err_code,
    output logic                            in_frame,
    output logic [CNT_WIDTH-1:0]            good_count,
    output logic [CNT_WIDTH-1:0]            bad_count,
    output logic [CNT_WIDTH-1:0]            beat_err_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int HI_WIDTH   = DATA_WIDTH - SEQ_WIDTH;

    typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

    state_t                state_q, state_d;
    logic [SEQ_WIDTH-1:0]  idx_q, idx_d;
    logic [SEQ_WIDTH-1:0]  len_q, len_d;
    logic [HI_WIDTH-1:0]   hi_q, hi_d;
    logic                  chk_hi_q, chk_hi_d;
    logic [3:0]            err_q, err_d;
    logic                  skip_q, skip_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_ok_q, frame_ok_d;
    logic [3:0]            err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0]  good_q, good_d;
    logic [CNT_WIDTH-1:0]  bad_q, bad_d;
    logic [CNT_WIDTH-1:0]  beat_err_q, beat_err_d;

    logic                  first;
    logic [SEQ_WIDTH-1:0]  ref_idx;
    logic [SEQ_WIDTH-1:0]  ref_len;
    logic [HI_WIDTH-1:0]   ref_hi;
    logic                  ref_chk;
    logic [KEEP_WIDTH-1:0] keep_inc;
    logic                  keep_ok;
    logic                  seq_err;
    logic [3:0]            err_acc;
    logic                  good_inc, bad_inc, beat_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] q,
                                                      input logic inc, input logic clr);
        if (clr)
            return '0;
        else if (inc && (q != '1))
            return q + CNT_WIDTH'(1);
        else
            return q;
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        hi_d         = hi_q;
        chk_hi_d     = chk_hi_q;
        err_d        = err_q;
        skip_d       = skip_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        err_code_d   = err_code_q;
        good_inc     = 1'b0;
        bad_inc      = 1'b0;
        beat_inc     = 1'b0;
        err_acc      = 4'b0;

        // The first beat of a frame is judged against live config, later beats against the latched copy.
        first    = (state_q == IDLE);
        ref_idx  = first ? '0 : idx_q;
        ref_len  = first ? cfg_length : len_q;
        ref_hi   = first ? cfg_hi_pattern : hi_q;
        ref_chk  = first ? cfg_check_hi : chk_hi_q;
        keep_inc = s00_axis_tkeep + KEEP_WIDTH'(1);
        keep_ok  = s00_axis_tlast ? ((s00_axis_tkeep != '0) && ((s00_axis_tkeep & keep_inc) == '0))
                                  : (s00_axis_tkeep == '1);
        seq_err  = (s00_axis_tdata[SEQ_WIDTH-1:0] != ref_idx) ||
                   (ref_chk && (s00_axis_tdata[DATA_WIDTH-1:SEQ_WIDTH] != ref_hi));

        if (s00_axis_tvalid && first && skip_q) begin
            if (s00_axis_tlast)
                skip_d = 1'b0;
        end else if (s00_axis_tvalid && first && !cfg_enable) begin
            if (!s00_axis_tlast)
                skip_d = 1'b1;
        end else if (s00_axis_tvalid) begin
            err_acc = first ? 4'b0 : err_q;
            if (first) begin
                len_d    = cfg_length;
                hi_d     = cfg_hi_pattern;
                chk_hi_d = cfg_check_hi;
            end
            if ((state_q != OVERRUN) && seq_err) begin
                err_acc[0] = 1'b1;
                beat_inc   = 1'b1;
            end
            if (!keep_ok)
                err_acc[3] = 1'b1;

            if (s00_axis_tlast) begin
                if (s00_axis_tuser)
                    err_acc[2] = 1'b1;
                if ((state_q != OVERRUN) && (ref_idx < ref_len))
                    err_acc[1] = 1'b1;
                frame_done_d = 1'b1;
                frame_ok_d   = (err_acc == 4'b0);
                err_code_d   = err_acc;
                good_inc     = (err_acc == 4'b0);
                bad_inc      = (err_acc != 4'b0);
                err_d        = 4'b0;
                idx_d        = '0;
                state_d      = IDLE;
            end else if (state_q == OVERRUN) begin
                err_d = err_acc;
            end else if (ref_idx == ref_len) begin
                err_acc[1] = 1'b1;
                err_d      = err_acc;
                state_d    = OVERRUN;
            end else begin
                err_d   = err_acc;
                idx_d   = ref_idx + SEQ_WIDTH'(1);
                state_d = ACTIVE;
            end
        end

        good_d     = sat_next(good_q, good_inc, stat_clear);
        bad_d      = sat_next(bad_q, bad_inc, stat_clear);
        beat_err_d = sat_next(beat_err_q, beat_inc, stat_clear);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            hi_q         <= '0;
            chk_hi_q     <= 1'b0;
            err_q        <= 4'b0;
            skip_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= 4'b0;
            good_q       <= '0;
            bad_q        <= '0;
            beat_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            chk_hi_q     <= chk_hi_d;
            err_q        <= err_d;
            skip_q       <= skip_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_code_q   <= err_code_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            beat_err_q   <= beat_err_d;
        end
    end

    assign frame_done     = frame_done_q;
    assign frame_ok       = frame_ok_q;
    assign frame_err_code = err_code_q;
    assign in_frame       = (state_q != IDLE);
    assign good_count     = good_q;
    assign bad_count      = bad_q;
    assign beat_err_count = beat_err_q;

endmodule

// File: tb/tb_eth_rx_packet_checker.sv
// Directed + randomized bench for eth_rx_packet_checker; a frame-level reference model
// derives each verdict from the beat list, and a 4-bit-counter instance checks saturation.
module tb_eth_rx_packet_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_length = '0;
    logic [15:0] cfg_hi = '0;
    logic        cfg_check_hi = 1'b0;
    logic        stat_clear = 1'b0;

    logic        frame_done, frame_ok, in_frame;
    logic [3:0]  err_code;
    logic [31:0] good_count, bad_count, beat_err_count;
    logic        s_done, s_ok, s_in_frame;
    logic [3:0]  s_code, s_good, s_bad, s_berr;

    always #5 clk = ~clk;

    eth_rx_packet_checker #(.DATA_WIDTH(32), .SEQ_WIDTH(16), .CNT_WIDTH(32)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tdata(tdata),
        .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
        .s00_axis_tuser(tuser), .cfg_enable(cfg_enable), .cfg_length(cfg_length),
        .cfg_hi_pattern(cfg_hi), .cfg_check_hi(cfg_check_hi), .stat_clear(stat_clear),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_err_code(err_code),
        .in_frame(in_frame), .good_count(good_count), .bad_count(bad_count),
        .beat_err_count(beat_err_count)
    );

    eth_rx_packet_checker #(.DATA_WIDTH(32), .SEQ_WIDTH(16), .CNT_WIDTH(4)) dut_sat (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tdata(tdata),
        .s00_axis_tkeep(tkeep), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
        .s00_axis_tuser(tuser), .cfg_enable(cfg_enable), .cfg_length(cfg_length),
        .cfg_hi_pattern(cfg_hi), .cfg_check_hi(cfg_check_hi), .stat_clear(stat_clear),
        .frame_done(s_done), .frame_ok(s_ok), .frame_err_code(s_code),
        .in_frame(s_in_frame), .good_count(s_good), .bad_count(s_bad),
        .beat_err_count(s_berr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] fr_data[$];
    logic [3:0]  fr_keep[$];
    bit          fr_user;
    int          exp_good = 0, exp_bad = 0, exp_berr = 0, exp_frames = 0;
    int          pulse_cnt = 0;
    int          m_len;
    logic [15:0] m_hi;
    bit          m_chk;

    always @(negedge clk) if (frame_done === 1'b1) pulse_cnt++;

    task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic setCfg(input int len, input logic [15:0] hi, input bit chk);
        cfg_length   = 16'(len);
        cfg_hi       = hi;
        cfg_check_hi = chk;
        m_len = len;
        m_hi  = hi;
        m_chk = chk;
    endtask

    task automatic buildGood(input int n);
        fr_data.delete();
        fr_keep.delete();
        for (int i = 0; i < n; i++) begin
            fr_data.push_back({m_hi, 16'(i)});
            fr_keep.push_back(4'hF);
        end
        fr_user = 1'b0;
    endtask

    // Frame-level rules: a beat i is data-checked only while i <= configured length.
    task automatic modelFrame(output logic [3:0] code, output int berr);
        int  n;
        bit  mism;
        code = 4'b0;
        berr = 0;
        n = fr_data.size();
        if (n != m_len + 1) code[1] = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i <= m_len) begin
                mism = (fr_data[i][15:0] != 16'(i)) || (m_chk && (fr_data[i][31:16] != m_hi));
                if (mism) begin
                    berr++;
                    code[0] = 1'b1;
                end
            end
            if (i < n - 1) begin
                if (fr_keep[i] != 4'hF) code[3] = 1'b1;
            end else begin
                if (!(fr_keep[i] == 4'h1 || fr_keep[i] == 4'h3 ||
                      fr_keep[i] == 4'h7 || fr_keep[i] == 4'hF)) code[3] = 1'b1;
            end
        end
        if (fr_user) code[2] = 1'b1;
    endtask

    task automatic applyStimulus(input bit en_first, input bit en_rest, input int gap_max);
        int n;
        n = fr_data.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_max > 0) begin
                tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            tvalid     = 1'b1;
            tdata      = fr_data[i];
            tkeep      = fr_keep[i];
            tlast      = (i == n - 1);
            tuser      = (i == n - 1) ? fr_user : 1'($urandom_range(0, 1));
            cfg_enable = (i == 0) ? en_first : en_rest;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] code;
        int         be;
        modelFrame(code, be);
        exp_frames++;
        exp_berr += be;
        if (code == 4'b0) exp_good++;
        else exp_bad++;
        expectEq({tag, "/done"}, frame_done, 1);
        expectEq({tag, "/ok"}, frame_ok, (code == 4'b0));
        expectEq({tag, "/code"}, err_code, code);
        expectEq({tag, "/good"}, good_count, exp_good);
        expectEq({tag, "/bad"}, bad_count, exp_bad);
        expectEq({tag, "/beat_err"}, beat_err_count, exp_berr);
        expectEq({tag, "/sat_good"}, s_good, sat15(exp_good));
        expectEq({tag, "/sat_bad"}, s_bad, sat15(exp_bad));
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkQuiet(input string tag);
        expectEq({tag, "/no_done"}, frame_done, 0);
        expectEq({tag, "/good"}, good_count, exp_good);
        expectEq({tag, "/bad"}, bad_count, exp_bad);
        expectEq({tag, "/beat_err"}, beat_err_count, exp_berr);
        expectEq({tag, "/pulses"}, pulse_cnt, exp_frames);
    endtask

    initial begin
        int          len, n, b;
        logic [15:0] h;

        repeat (3) @(posedge clk);
        #1;
        expectEq("reset/done", frame_done, 0);
        expectEq("reset/ok", frame_ok, 0);
        expectEq("reset/code", err_code, 0);
        expectEq("reset/in_frame", in_frame, 0);
        expectEq("reset/good", good_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back good frames");
        setCfg(3, 16'hA5A5, 1'b1);
        for (int f = 0; f < 10; f++) begin
            buildGood(4);
            applyStimulus(1'b1, 1'b1, 0);
            checkOutput("b2b");
        end
        idle(2);
        checkQuiet("b2b_end");

        $display("[TB] sequence error and randomized frames");
        buildGood(4);
        fr_data[2] = {16'hA5A5, 16'h0005};
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("seq_err");
        buildGood(4);
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("seq_recover");
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(0, 6);
            h = 16'($urandom);
            setCfg(len, h, 1'($urandom_range(0, 1)));
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
            buildGood(n);
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, n - 1);
                fr_data[b] = fr_data[b] ^ (32'h1 << $urandom_range(0, 31));
            end
            applyStimulus(1'b1, 1'b1, 2);
            checkOutput("rand");
        end
        idle(2);
        checkQuiet("rand_end");

        $display("[TB] length errors");
        setCfg(3, 16'hA5A5, 1'b1);
        buildGood(2);
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("short");
        buildGood(6);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("overrun");
        buildGood(4);
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("len_recover");

        $display("[TB] tuser and tkeep errors");
        buildGood(4);
        fr_user = 1'b1;
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("tuser");
        buildGood(4);
        fr_keep[1] = 4'b0011;
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("keep_mid");
        buildGood(4);
        fr_keep[3] = 4'b0011;
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("keep_last_ok");
        buildGood(4);
        fr_keep[3] = 4'b0101;
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("keep_last_bad");
        idle(2);
        expectEq("held/code", err_code, 4'b1000);
        expectEq("held/ok", frame_ok, 0);
        checkQuiet("keep_end");

        $display("[TB] single-beat frames and saturation");
        setCfg(0, 16'h3C3C, 1'b1);
        for (int f = 0; f < 8; f++) begin
            buildGood(1);
            applyStimulus(1'b1, 1'b1, 0);
            checkOutput("single");
        end
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        exp_good = 0; exp_bad = 0; exp_berr = 0;
        expectEq("clear/good", good_count, 0);
        expectEq("clear/sat_bad", s_bad, 0);
        for (int f = 0; f < 20; f++) begin
            buildGood(1);
            applyStimulus(1'b1, 1'b1, 0);
            checkOutput("sat");
        end
        expectEq("sat/main_good", good_count, 20);
        expectEq("sat/sat_good", s_good, 15);
        buildGood(1);
        stat_clear = 1'b1;
        applyStimulus(1'b1, 1'b1, 0);
        stat_clear = 1'b0;
        exp_frames++;
        exp_good = 0; exp_bad = 0; exp_berr = 0;
        expectEq("clr_coinc/done", frame_done, 1);
        expectEq("clr_coinc/good", good_count, 0);
        expectEq("clr_coinc/sat_good", s_good, 0);
        idle(1);
        expectEq("clr_coinc/ok_held", frame_ok, 1);
        checkQuiet("clr_end");

        $display("[TB] reset mid-frame");
        setCfg(3, 16'hA5A5, 1'b1);
        buildGood(1);
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("pre_reset");
        buildGood(4);
        for (int i = 0; i < 2; i++) begin
            tvalid = 1'b1; tdata = fr_data[i]; tkeep = 4'hF;
            tlast = 1'b0; tuser = 1'b0; cfg_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        expectEq("mid/in_frame", in_frame, 1);
        tdata = fr_data[2];
        #2 rst_n = 1'b0;
        #1;
        expectEq("rst/done", frame_done, 0);
        expectEq("rst/ok", frame_ok, 0);
        expectEq("rst/code", err_code, 0);
        expectEq("rst/in_frame", in_frame, 0);
        expectEq("rst/good", good_count, 0);
        expectEq("rst/sat_good", s_good, 0);
        tvalid = 1'b0;
        exp_good = 0; exp_bad = 0; exp_berr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        buildGood(4);
        applyStimulus(1'b1, 1'b1, 0);
        checkOutput("post_reset");
        idle(2);
        checkQuiet("post_reset_end");

        $display("[TB] disabled frames");
        buildGood(4);
        applyStimulus(1'b0, 1'b0, 1);
        buildGood(4);
        fr_data[1] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1, 0);
        idle(2);
        checkQuiet("disabled");
        buildGood(4);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("enable_drop");
        idle(2);
        checkQuiet("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
